// File: rtl/ram_lat_pkg.sv
// ram_lat_pkg: LFSR, seed and latency constants shared by the latency/stall RAM wrapper
package ram_lat_pkg;
  localparam int LFSR_W = 16;
  typedef logic [LFSR_W-1:0] lfsr_t;
  localparam lfsr_t LFSR_TAPS = 16'hB400;
  localparam lfsr_t INSTR_SEED_DEF = 16'hACE1;
  localparam lfsr_t DATA_SEED_DEF = 16'h1D0F;
  localparam int MAX_LATENCY = 4;
  function automatic lfsr_t lfsr_next(input lfsr_t s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/dp_ram.sv
// dp_ram: dual-port byte-enable RAM, registered read data, reads see pre-write contents
module dp_ram #(
  parameter int ADDR_WIDTH = 22
) (
  input  logic                  clk,
  input  logic                  en_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [31:0]           wdata_a_i,
  output logic [31:0]           rdata_a_o,
  input  logic                  we_a_i,
  input  logic [3:0]            be_a_i,
  input  logic                  en_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [31:0]           wdata_b_i,
  output logic [31:0]           rdata_b_o,
  input  logic                  we_b_i,
  input  logic [3:0]            be_b_i
);
  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  logic [31:0] mem [WORDS];
  logic [ADDR_WIDTH-3:0] wa, wb;
  logic [3:0] unused_lsb;
  assign wa = addr_a_i[ADDR_WIDTH-1:2];
  assign wb = addr_b_i[ADDR_WIDTH-1:2];
  assign unused_lsb = {addr_a_i[1:0], addr_b_i[1:0]};
  always_ff @(posedge clk) begin
    if (en_a_i) begin
      rdata_a_o <= mem[wa];
      if (we_a_i)
        for (int i = 0; i < 4; i++)
          if (be_a_i[i]) mem[wa][8*i +: 8] <= wdata_a_i[8*i +: 8];
    end
    if (en_b_i) begin
      rdata_b_o <= mem[wb];
      if (we_b_i)
        for (int i = 0; i < 4; i++)
          if (be_b_i[i]) mem[wb][8*i +: 8] <= wdata_b_i[8*i +: 8];
    end
  end
endmodule

// File: rtl/ram_lat_port.sv
// ram_lat_port: LFSR stall, grant and fixed-latency in-order response pipeline for one RAM port
module ram_lat_port
  import ram_lat_pkg::*;
#(
  parameter int    LATENCY  = 1,
  parameter bit    STALL_EN = 1'b0,
  parameter lfsr_t SEED     = INSTR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        en_o,
  input  logic [31:0] ram_rdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("ram_lat_port: LATENCY=%0d outside 1..%0d", LATENCY, MAX_LATENCY);
  end
  lfsr_t lfsr_q, lfsr_d;
  logic [LATENCY-1:0] valid_q, valid_d;
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
    gnt_o = req_i & ~(STALL_EN & lfsr_q[0]);
    en_o = req_i & gnt_o;
    valid_d = LATENCY'({valid_q, en_o});
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
      valid_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      valid_q <= valid_d;
    end
  end
  assign rvalid_o = valid_q[LATENCY-1];
  if (LATENCY == 1) begin : g_pass
    assign rdata_o = ram_rdata_i;
  end else begin : g_delay
    localparam int RW = 32 * (LATENCY - 1);
    logic [LATENCY-2:0][31:0] rdata_q, rdata_d;
    always_comb rdata_d = RW'({rdata_q, ram_rdata_i});
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else rdata_q <= rdata_d;
    end
    assign rdata_o = rdata_q[LATENCY-2];
  end
endmodule

// File: rtl/ram_lat.sv
// ram_lat: core-facing instruction/data RAM wrapper with per-port read latency and optional grant stalls
module ram_lat
  import ram_lat_pkg::*;
#(
  parameter int    ADDR_WIDTH    = 22,
  parameter int    INSTR_LATENCY = 1,
  parameter int    DATA_LATENCY  = 1,
  parameter bit    STALL_EN      = 1'b0,
  parameter lfsr_t INSTR_SEED    = INSTR_SEED_DEF,
  parameter lfsr_t DATA_SEED     = DATA_SEED_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o
);
  logic instr_en, data_en;
  logic [31:0] instr_ram_rdata, data_ram_rdata;
  ram_lat_port #(.LATENCY(INSTR_LATENCY), .STALL_EN(STALL_EN), .SEED(INSTR_SEED)) u_instr (
    .clk(clk), .rst(rst), .req_i(instr_req_i), .gnt_o(instr_gnt_o), .en_o(instr_en),
    .ram_rdata_i(instr_ram_rdata), .rvalid_o(instr_rvalid_o), .rdata_o(instr_rdata_o)
  );
  ram_lat_port #(.LATENCY(DATA_LATENCY), .STALL_EN(STALL_EN), .SEED(DATA_SEED)) u_data (
    .clk(clk), .rst(rst), .req_i(data_req_i), .gnt_o(data_gnt_o), .en_o(data_en),
    .ram_rdata_i(data_ram_rdata), .rvalid_o(data_rvalid_o), .rdata_o(data_rdata_o)
  );
  dp_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .en_a_i(instr_en), .addr_a_i(instr_addr_i), .wdata_a_i(32'h0), .rdata_a_o(instr_ram_rdata),
    .we_a_i(1'b0), .be_a_i(4'b1111),
    .en_b_i(data_en), .addr_b_i(data_addr_i), .wdata_b_i(data_wdata_i), .rdata_b_o(data_ram_rdata),
    .we_b_i(data_we_i), .be_b_i(data_be_i)
  );
endmodule
